seq_function_unit: RTL and testbench

Parametrised, handshaked successor to the RISC datapath function unit: registered ALU/shifter with valid/ready on both sides, WIDTH-generic operands, N-bit shifts with shift-out carry, and a multi-cycle iterative shifter. It sits between the register-file read stage and write-back. A single result register decouples it from write-back stalls.

---
 rtl/seq_function_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_seq_function_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_function_unit.sv
// seq_function_unit
//
// Registered ALU/shifter that sits between register-file read and write-back.
// Both sides use a valid/ready handshake. A single result register holds the
// result, together with the C/V/N/Z flags, until write-back takes it.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (A, B, FS, SH captured on accept)
//   A, B                WIDTH-bit operands
//   FS                  5-bit function select
//   SH                  shift amount (SHW bits)
//   out_valid/out_ready result handshake
//   out, C, V, N, Z     registered result and flags
//
// Build option:
//   FU_BARREL_EN  when defined, shifts go through a combinational barrel
//                 shifter and finish in one cycle. When it is not defined,
//                 shifts run one bit per cycle in a SHIFT state.

module seq_function_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    input  logic [SHW-1:0]   SH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);

    localparam logic [4:0] FS_AND  = 5'b01000;
    localparam logic [4:0] FS_OR   = 5'b01010;
    localparam logic [4:0] FS_XOR  = 5'b01100;
    localparam logic [4:0] FS_NOTA = 5'b01110;
    localparam logic [4:0] FS_B    = 5'b10000;
    localparam logic [4:0] FS_SRL  = 5'b10100;
    localparam logic [4:0] FS_SLL  = 5'b11000;

    // Combinational function result for the op presented on the inputs
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
`ifdef FU_BARREL_EN
    logic [WIDTH:0]   srl_ext;
    logic [WIDTH:0]   sll_ext;
`endif

    // Result register and flags
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             n_q, n_d;
    logic             z_q, z_d;

    // Control
    logic             drain_ok;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c;
    logic             load_v;

`ifndef FU_BARREL_EN
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] work_step;
    logic             step_out;
    logic             is_shift;
`endif

    // The arithmetic group is one adder: FS[2:1] picks the second operand
    // (0, B, ~B, all-ones) and FS[0] is the carry-in. That gives increment,
    // subtract and decrement without separate hardware.
    always_comb begin
        b_op    = '0;
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
`ifdef FU_BARREL_EN
        srl_ext = '0;
        sll_ext = '0;
`endif

        case (FS[2:1])
            2'b00:   b_op = '0;
            2'b01:   b_op = B;
            2'b10:   b_op = ~B;
            default: b_op = '1;
        endcase
        sum_ext = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, FS[0]};

        casez (FS)
            5'b00???: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] == b_op[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            FS_AND:  alu_res = A & B;
            FS_OR:   alu_res = A | B;
            FS_XOR:  alu_res = A ^ B;
            FS_NOTA: alu_res = ~A;
            FS_B:    alu_res = B;
`ifdef FU_BARREL_EN
            // One extra bit below (right) or above (left) the operand catches
            // the last bit shifted out. It stays 0 when SH is 0.
            FS_SRL: begin
                srl_ext = {B, 1'b0} >> SH;
                alu_res = srl_ext[WIDTH:1];
                alu_c   = srl_ext[0];
            end
            FS_SLL: begin
                sll_ext = {1'b0, B} << SH;
                alu_res = sll_ext[WIDTH-1:0];
                alu_c   = sll_ext[WIDTH];
            end
`else
            // The iterative shifter handles SH>0. This path only serves SH==0,
            // which is a plain transfer of B with no carry.
            FS_SRL:  alu_res = B;
            FS_SLL:  alu_res = B;
`endif
            default: alu_res = '0;
        endcase
    end

    // Handshake, shift sequencing and result-register loading. The result
    // register may load on the same edge that write-back drains it. When the
    // register is full and not draining, the unit stalls.
    always_comb begin
        drain_ok    = !out_valid_q || out_ready;
`ifdef FU_BARREL_EN
        in_ready    = drain_ok;
`else
        in_ready    = (state_q == IDLE) && drain_ok;
`endif
        accept      = in_valid && in_ready;
        load        = 1'b0;
        load_res    = alu_res;
        load_c      = alu_c;
        load_v      = alu_v;
        out_valid_d = out_valid_q && !out_ready;

`ifdef FU_BARREL_EN
        load = accept;
`else
        state_d   = state_q;
        work_d    = work_q;
        count_d   = count_q;
        dir_d     = dir_q;
        is_shift  = (FS == FS_SRL) || (FS == FS_SLL);
        work_step = dir_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
        step_out  = dir_q ? work_q[WIDTH-1] : work_q[0];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift && (SH != '0)) begin
                        work_d  = B;
                        count_d = SH;
                        dir_d   = (FS == FS_SLL);
                        state_d = SHIFT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // The final step writes straight into the result register.
                // This makes the result valid SH edges after accept. If the
                // result register is still full, the final step waits.
                if (count_q > SHW'(1)) begin
                    work_d  = work_step;
                    count_d = count_q - SHW'(1);
                end else if (drain_ok) begin
                    work_d   = work_step;
                    count_d  = '0;
                    load     = 1'b1;
                    load_res = work_step;
                    load_c   = step_out;
                    load_v   = 1'b0;
                    state_d  = IDLE;
                end
            end
        endcase
`endif

        out_d = out_q;
        c_d   = c_q;
        v_d   = v_q;
        n_d   = n_q;
        z_d   = z_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_d       = load_res;
            c_d         = load_c;
            v_d         = load_v;
            n_d         = load_res[WIDTH-1];
            z_d         = (load_res == '0);
        end
    end

    // All state registers. A reset during a shift discards the op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
`ifndef FU_BARREL_EN
            state_q     <= IDLE;
            work_q      <= '0;
            count_q     <= '0;
            dir_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            c_q         <= c_d;
            v_q         <= v_d;
            n_q         <= n_d;
            z_q         <= z_d;
`ifndef FU_BARREL_EN
            state_q     <= state_d;
            work_q      <= work_d;
            count_q     <= count_d;
            dir_q       <= dir_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign C         = c_q;
    assign V         = v_q;
    assign N         = n_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_seq_function_unit.sv
// Testbench for seq_function_unit.
// Directed operations push their hand-computed results into a scoreboard.
// A monitor pops the scoreboard and compares each time a result is handed over.

module tb_seq_function_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  cvnz;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [4:0]       FS = '0;
    logic [SHW-1:0]   SH = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_res;
    logic             C, V, N, Z;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   results_seen = 0;

    seq_function_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .FS        (FS),
        .SH        (SH),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_res),
        .C         (C),
        .V         (V),
        .N         (N),
        .Z         (Z)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Shared comparison and bookkeeping
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor. It samples on the falling edge, so a handshake seen
    // here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                results_seen++;
                checkOutput($sformatf("result_%0d_out", results_seen), out_res, e.res);
                checkOutput($sformatf("result_%0d_cvnz", results_seen), {28'd0, C, V, N, Z}, {28'd0, e.cvnz});
            end
        end
    end

    // Push the expected result and present the op. Then wait, with a time
    // limit, for the accepting edge. The task returns 1 ns after that edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [4:0] fs,
                                 input logic [4:0] sh, input logic [31:0] eres, input logic [3:0] ecvnz);
        bit accepted;
        exp_t e;
        e.res  = eres;
        e.cvnz = ecvnz;
        sb.push_back(e);
        A = a;
        B = b;
        FS = fs;
        SH = sh;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait, with a time limit, until all expected results have been consumed
    task automatic drainAll();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1);
    end

    initial begin
        int stale;

        // Reset with an op presented: nothing may be accepted
        rst_n = 1'b0;
        in_valid = 1'b1;
        A = 32'h1;
        B = 32'h2;
        FS = 5'b00010;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out", out_res, 32'd0);
        checkOutput("reset_cvnz", {28'd0, C, V, N, Z}, 32'd0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("post_reset_no_result", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // A+B+1, one-cycle latency
        applyStimulus(32'h00000A85, 32'h00009492, 5'b00011, 5'd0, 32'h00009F18, 4'b0000);
        checkOutput("alu_latency", {31'd0, out_valid}, 32'd1);

        // Logical right shift by 4
        applyStimulus(32'h0, 32'h94925643, 5'b10100, 5'd4, 32'h09492564, 4'b0000);
`ifdef FU_BARREL_EN
        checkOutput("shift_latency", {31'd0, out_valid}, 32'd1);
`else
        checkOutput("shift_busy_0", {30'd0, out_valid, in_ready}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("shift_busy_%0d", i), {30'd0, out_valid, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("shift_done", {31'd0, out_valid}, 32'd1);
`endif

        // Shift boundaries: carry out on left shifts, SH=0, and the maximum amount
        applyStimulus(32'h0, 32'h80000001, 5'b11000, 5'd1,  32'h00000002, 4'b1000);
        applyStimulus(32'h0, 32'h00000003, 5'b11000, 5'd31, 32'h80000000, 4'b1010);
        applyStimulus(32'h0, 32'h0000000F, 5'b10100, 5'd0,  32'h0000000F, 4'b0000);

        // Arithmetic, issued back to back
        applyStimulus(32'h7FFFFFFF, 32'h0, 5'b00001, 5'd0, 32'h80000000, 4'b0110);
        applyStimulus(32'h00000005, 32'h5, 5'b00101, 5'd0, 32'h00000000, 4'b1001);
        applyStimulus(32'h00000000, 32'h0, 5'b00110, 5'd0, 32'hFFFFFFFF, 4'b0010);
        applyStimulus(32'h80000000, 32'h0, 5'b00110, 5'd0, 32'h7FFFFFFF, 4'b1100);
        applyStimulus(32'h12345678, 32'h0, 5'b00111, 5'd0, 32'h12345678, 4'b1000);

        // Logic, transfer and undefined codes
        applyStimulus(32'hF0F0F0F0, 32'hFF00FF00, 5'b01000, 5'd0, 32'hF000F000, 4'b0010);
        applyStimulus(32'hF0F0F0F0, 32'hFF00FF00, 5'b01010, 5'd0, 32'hFFF0FFF0, 4'b0010);
        applyStimulus(32'hF0F0F0F0, 32'hFF00FF00, 5'b01100, 5'd0, 32'h0FF00FF0, 4'b0000);
        applyStimulus(32'hF0F0F0F0, 32'hFF00FF00, 5'b01110, 5'd0, 32'h0F0F0F0F, 4'b0000);
        applyStimulus(32'hFFFFFFFF, 32'h00000000, 5'b10000, 5'd0, 32'h00000000, 4'b0001);
        applyStimulus(32'h0000FFFF, 32'h0000FFFF, 5'b01001, 5'd0, 32'h00000000, 4'b0001);
        applyStimulus(32'h0000FFFF, 32'h0000FFFF, 5'b11111, 5'd0, 32'h00000000, 4'b0001);
        drainAll();

        // Backpressure: the held result stays stable, then drain and accept happen on one edge
        out_ready = 1'b0;
        applyStimulus(32'h00000011, 32'h0, 5'b00000, 5'd0, 32'h00000011, 4'b0000);
        checkOutput("bp_loaded", {31'd0, out_valid}, 32'd1);
        sb.push_back('{res: 32'h80000022, cvnz: 4'b0010});
        A = 32'h80000022;
        FS = 5'b00000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_hold_out_%0d", i), out_res, 32'h00000011);
            checkOutput($sformatf("bp_hold_flags_%0d", i), {26'd0, out_valid, in_ready, C, V, N, Z}, 32'h20);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp_valid_stays", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_new_out", out_res, 32'h80000022);
        drainAll();

        // Reset in the middle of a long shift
        A = 32'h0;
        B = 32'hFFFFFFFF;
        FS = 5'b10100;
        SH = 5'd20;
`ifdef FU_BARREL_EN
        sb.push_back('{res: 32'h00000FFF, cvnz: 4'b1000});
`endif
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("midshift_accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midshift_reset_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midshift_reset_out", out_res, 32'd0);
        checkOutput("midshift_reset_cvnz", {28'd0, C, V, N, Z}, 32'd0);
        rst_n = 1'b1;
        checkOutput("midshift_idle_ready", {31'd0, in_ready}, 32'd1);
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("midshift_no_stale", stale, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(32'h00000003, 32'h00000004, 5'b00010, 5'd0, 32'h00000007, 4'b0000);
        drainAll();

        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
